// File: rtl/cadence_meas.sv
// cadence_meas: conditions the crank cadence sensor, measures the rise-to-rise period
// and converts it to a saturating 5-bit cadence value with a fixed-latency divider.
module cadence_meas #(
    parameter int unsigned FILT_CYC = 16,
    parameter int unsigned PER_W    = 24,
    parameter int unsigned CAD_NUM  = 2**26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cadence,
    output logic       cadence_rise,
    output logic [4:0] cadence_vec,
    output logic       vec_valid,
    output logic       not_pedaling
);
    localparam int unsigned W  = PER_W + 5;
    localparam int unsigned FW = $clog2(FILT_CYC);
    localparam logic [W-1:0] CAD = W'(CAD_NUM);

    typedef enum logic [1:0] {IDLE, CHK, DIV, UPD} state_t;

    logic [1:0]       sync_q;
    logic             filt_q, filt_d, filt_p_q, top_q;
    logic [FW-1:0]    fcnt_q, fcnt_d;
    logic [PER_W-1:0] cnt_q, cnt_d, per_q, per_d;
    logic             armed_q, armed_d, sat_q, sat_d, np_q, np_d;
    logic [W-1:0]     rem_q, rem_d, sub;
    logic [2:0]       i_q, i_d;
    logic [3:0]       quo_q, quo_d;
    logic [4:0]       vec_q, vec_d;
    state_t           st_q, st_d;
    logic             stall, cap, ge;

    assign cadence_rise = filt_q & ~filt_p_q;
    // Stall fires once, in the first cycle the counter reads saturated, so a later rise can re-arm.
    assign stall        = &cnt_q & ~top_q;
    assign cap          = cadence_rise & armed_q & ~stall;
    assign sub          = W'(per_q) << i_q;
    assign ge           = rem_q >= sub;
    assign cadence_vec  = vec_q;
    assign not_pedaling = np_q;
    assign vec_valid    = st_q == UPD;

    always_comb begin
        filt_d  = filt_q;
        fcnt_d  = '0;
        if (sync_q[1] != filt_q) begin
            if (fcnt_q == FW'(FILT_CYC - 1)) filt_d = sync_q[1];
            else fcnt_d = fcnt_q + 1'b1;
        end
        cnt_d   = cadence_rise ? PER_W'(1) : (&cnt_q ? cnt_q : cnt_q + 1'b1);
        armed_d = stall ? 1'b0 : (armed_q | cadence_rise);
        per_d   = cap ? cnt_q : per_q;
        st_d    = st_q;
        sat_d   = sat_q;
        rem_d   = rem_q;
        i_d     = i_q;
        quo_d   = quo_q;
        vec_d   = vec_q;
        np_d    = np_q;
        case (st_q)
            CHK: begin
                sat_d = (W'(per_q) << 5) <= CAD;
                rem_d = CAD;
                i_d   = 3'd4;
                st_d  = DIV;
            end
            DIV: begin
                rem_d = ge ? rem_q - sub : rem_q;
                quo_d = {quo_q[2:0], ge};
                i_d   = i_q - 1'b1;
                if (i_q == 3'd0 && !cap) begin
                    vec_d = sat_q ? 5'd31 : {quo_q, ge};
                    np_d  = 1'b0;
                    st_d  = UPD;
                end
            end
            default: st_d = IDLE;
        endcase
        if (cap) st_d = CHK;
        if (stall) begin
            st_d  = IDLE;
            vec_d = '0;
            np_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            filt_q   <= 1'b0;
            filt_p_q <= 1'b0;
            fcnt_q   <= '0;
            cnt_q    <= '0;
            top_q    <= 1'b0;
            per_q    <= '0;
            armed_q  <= 1'b0;
            sat_q    <= 1'b0;
            rem_q    <= '0;
            i_q      <= '0;
            quo_q    <= '0;
            vec_q    <= '0;
            np_q     <= 1'b1;
            st_q     <= IDLE;
        end else begin
            sync_q   <= {sync_q[0], cadence};
            filt_q   <= filt_d;
            filt_p_q <= filt_q;
            fcnt_q   <= fcnt_d;
            cnt_q    <= cnt_d;
            top_q    <= &cnt_q;
            per_q    <= per_d;
            armed_q  <= armed_d;
            sat_q    <= sat_d;
            rem_q    <= rem_d;
            i_q      <= i_d;
            quo_q    <= quo_d;
            vec_q    <= vec_d;
            np_q     <= np_d;
            st_q     <= st_d;
        end
    end
endmodule

// File: tb/tb_cadence_meas.sv
// tb_cadence_meas: directed cadence stimulus, checked every cycle against a
// behavioural model plus hand-computed literal expectations.
`timescale 1ns/1ps
module tb_cadence_meas;
    localparam int PER_W = 12;
    localparam int CAD   = 16384;
    localparam int SMAX  = 4095;

    logic       clk = 1'b0, rst_n = 1'b0, cadence = 1'b0;
    logic       cadence_rise, vec_valid, not_pedaling;
    logic [4:0] cadence_vec;

    int checks = 0, errors = 0;
    int tcyc = 0, nrise = 0, nvv = 0, rise_cyc = 0, vv_cyc = 0, vv_vec = 0;
    int r0, v0, p0;

    // model state: cycle index since reset, last filtered rise, pending update
    int         m_cyc = 0, m_last = -1, m_pend = -1, m_pval = 0, m_vec = 0, m_raw, m_cnt;
    logic       m_s1 = 0, m_sy = 0, m_filt = 0, m_filtp = 0, m_armed = 0, m_np = 1, m_vv = 0;
    logic [15:0] m_win = '0;

    cadence_meas #(.FILT_CYC(16), .PER_W(PER_W), .CAD_NUM(CAD)) dut (
        .clk(clk), .rst_n(rst_n), .cadence(cadence), .cadence_rise(cadence_rise),
        .cadence_vec(cadence_vec), .vec_valid(vec_valid), .not_pedaling(not_pedaling));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        tcyc++;
    end

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_cyc = 0; m_last = -1; m_pend = -1; m_pval = 0; m_vec = 0;
            m_s1 = 0; m_sy = 0; m_filt = 0; m_filtp = 0; m_armed = 0; m_np = 1; m_vv = 0;
            m_win = '0;
        end else begin
            m_raw = (m_last < 0) ? m_cyc : m_cyc - m_last;
            m_cnt = (m_raw > SMAX) ? SMAX : m_raw;
            if (m_raw == SMAX) begin
                m_vec = 0; m_np = 1; m_armed = 0; m_pend = -1;
            end else if (m_filt && !m_filtp) begin
                if (m_armed) begin
                    m_pend = m_cyc + 7;
                    m_pval = (m_cnt == 0 || CAD / m_cnt > 31) ? 31 : CAD / m_cnt;
                end
                m_armed = 1;
            end
            if (m_filt && !m_filtp) m_last = m_cyc;
            m_vv = (m_cyc + 1 == m_pend);
            if (m_vv) begin
                m_vec = m_pval; m_np = 0; m_pend = -1;
            end
            // level flips once the last 16 synchronized samples all disagree with it
            m_win   = {m_win[14:0], m_sy};
            m_filtp = m_filt;
            if (m_win == {16{!m_filt}}) m_filt = !m_filt;
            m_sy = m_s1;
            m_s1 = cadence;
            m_cyc++;
        end
    end

    initial forever begin
        @(negedge clk);
        chk("cadence_rise", cadence_rise, m_filt & ~m_filtp);
        chk("cadence_vec", cadence_vec, m_vec);
        chk("vec_valid", vec_valid, m_vv);
        chk("not_pedaling", not_pedaling, m_np);
        if (cadence_rise) begin
            rise_cyc = tcyc;
            nrise++;
        end
        if (vec_valid) begin
            vv_cyc = tcyc;
            vv_vec = cadence_vec;
            nvv++;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        cadence = 1'b0;
        rst_n   = 1'b0;
        wait_cyc(3);
        rst_n   = 1'b1;
    endtask

    // pin high for 100 cycles, next pin rise 'gap' cycles after this one
    task automatic pulse(input int gap, input int exp, input string nm);
        int rs, vs;
        rs = nrise;
        vs = nvv;
        cadence = 1'b1;
        wait_cyc(100);
        chk({nm, " rise_count"}, nrise - rs, 1);
        if (exp < 0) chk({nm, " no_update"}, nvv - vs, 0);
        else begin
            chk({nm, " update_count"}, nvv - vs, 1);
            chk({nm, " latency"}, vv_cyc - rise_cyc, 7);
            chk({nm, " vec"}, vv_vec, exp);
            chk({nm, " model_vec"}, m_vec, exp);
            chk({nm, " not_pedaling"}, not_pedaling, 0);
        end
        cadence = 1'b0;
        wait_cyc(gap - 100);
    endtask

    initial begin
        wait_cyc(2);
        for (int k = 0; k < 8; k++) begin
            cadence = k[0];
            wait_cyc(3);
        end
        chk("reset vec", cadence_vec, 0);
        chk("reset np", not_pedaling, 1);
        chk("reset valid", vec_valid, 0);
        chk("reset rise", cadence_rise, 0);
        cadence = 1'b0;
        rst_n   = 1'b1;
        wait_cyc(20);

        r0 = nrise;
        cadence = 1'b1;
        wait_cyc(10);
        cadence = 1'b0;
        wait_cyc(40);
        chk("glitch10 rises", nrise - r0, 0);
        chk("glitch10 model filt", m_filt, 0);
        p0 = tcyc;
        cadence = 1'b1;
        wait_cyc(40);
        cadence = 1'b0;
        wait_cyc(40);
        chk("pulse40 rises", nrise - r0, 1);
        chk("pulse40 delay", rise_cyc - p0, 18);

        do_reset();
        pulse(1024, -1, "arm");
        pulse(3000, 16, "p1024");
        pulse(300, 5, "p3000");
        pulse(300, 31, "p300");
        pulse(1024, 31, "p300b");
        pulse(4200, 16, "p1024b");
        chk("stall vec", cadence_vec, 0);
        chk("stall np", not_pedaling, 1);
        chk("stall model np", m_np, 1);
        pulse(1024, -1, "after_stall");
        pulse(1024, 16, "rearm");

        r0 = nrise;
        cadence = 1'b1;
        for (int k = 0; k < 40 && nrise == r0; k++) @(posedge clk);
        chk("midrst rise seen", nrise - r0, 1);
        wait_cyc(3);
        chk("midrst pre vec", cadence_vec, 16);
        rst_n = 1'b0;
        #1;
        chk("midrst vec", cadence_vec, 0);
        chk("midrst np", not_pedaling, 1);
        chk("midrst valid", vec_valid, 0);
        chk("midrst rise", cadence_rise, 0);
        wait_cyc(3);
        v0 = nvv;
        rst_n = 1'b1;
        wait_cyc(60);
        chk("midrst no update", nvv - v0, 0);
        cadence = 1'b0;
        wait_cyc(50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cadence_meas.md
Name: cadence_meas

Overview:
- Upstream stage that produces the cadence_vec input of the desired-drive (assist) calculation.
- Conditions the raw crank cadence sensor with a synchronizer and glitch filter, then measures the clock-cycle period between filtered rising edges.
- Converts the period to a 5-bit cadence value, cadence_vec = min(31, CAD_NUM / period), using a fixed-latency sequential restoring divider.
- Declares "not pedaling" and forces cadence_vec to 0 when edges stop.

Parameters:
- FILT_CYC, 16: consecutive stable cycles required before the filtered cadence changes level.
- PER_W, 24: period counter width. The counter saturates at all-ones, and saturation is the stall condition.
- CAD_NUM, 2**26: dividend constant. Width is PER_W+5 bits; CAD_NUM < 2**(PER_W+5) is required.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- cadence, input, 1: raw cadence sensor, asynchronous to clk.
- cadence_rise, output, 1: one-cycle pulse on each filtered rising edge.
- cadence_vec, output, 5: cadence value consumed by the assist calculation.
- vec_valid, output, 1: one-cycle pulse on each cadence_vec update.
- not_pedaling, output, 1: high when no valid cadence is established.

Behaviour:
- Reset (async, rst_n low):
  - cadence_vec=0, vec_valid=0, cadence_rise=0, not_pedaling=1.
  - Filter level=0, synchronizer=0, period counter=0, divider in IDLE, armed=0.
  - Reset asserted mid-division aborts the division; no update occurs after release.
- Synchronizer: two flops on cadence, producing sync.
- Glitch filter:
  - A FILT_CYC-wide counter increments while sync != filt and clears whenever sync == filt.
  - When the counter reaches FILT_CYC-1 with sync != filt, filt takes sync and the counter clears.
  - Pulses shorter than FILT_CYC cycles never change filt.
- cadence_rise is high exactly in the first cycle in which filt reads 1.
- Period counter cnt (PER_W bits):
  - On cadence_rise: cnt <= 1.
  - Otherwise: cnt <= cnt+1, saturating at 2**PER_W-1.
  - For rises at cycles t0 and t1, cnt equals t1-t0 in cycle t1.
- Arming:
  - A rise while armed=0 only sets armed=1; there is no period capture and no division.
  - A rise while armed=1 captures per_cap <= cnt and starts the divider.
- Stall: when cnt reaches 2**PER_W-1:
  - cadence_vec <= 0, not_pedaling <= 1, armed <= 0.
  - Any division in progress is aborted and vec_valid is not pulsed.
  - Stall wins over a rise in the same cycle.
- Divider FSM, with states IDLE, CHK, DIV, UPD:
  - Let R be the cadence_rise cycle of a capturing rise.
  - CHK (cycle R+1): sat <= (per_cap*32 <= CAD_NUM). rem <= CAD_NUM. i <= 4.
  - DIV (cycles R+2..R+6): if rem >= per_cap<<i, then rem -= per_cap<<i and q[i]=1; otherwise q[i]=0. After i=0, go to UPD.
  - Update: on the edge ending R+6, cadence_vec <= sat ? 31 : q and not_pedaling <= 0.
  - vec_valid is high only in cycle R+7.
  - Latency is fixed at 7 cycles regardless of saturation. All arithmetic is unsigned at PER_W+5 bits.
- A capturing rise during CHK/DIV aborts the current division and restarts CHK with the new per_cap. Only the latest period produces an update.
- cadence_vec holds its value between updates. It changes only on an update, on stall, or on reset.

Test Plan:
All scenarios use overrides PER_W=12, CAD_NUM=16384, FILT_CYC=16.
- Reset: hold rst_n low, toggle cadence -> cadence_vec=0, not_pedaling=1, vec_valid=0, cadence_rise=0 throughout.
- Glitch rejection: 10-cycle high pulse on cadence -> no cadence_rise, filt stays 0. A 40-cycle pulse -> exactly one cadence_rise, about FILT_CYC+2 cycles after the pin rises.
- Nominal: clean rises 1024 cycles apart -> first rise arms only. Second rise: cadence_vec=16 visible at R+7, vec_valid single pulse, not_pedaling=0. Then 3000-cycle spacing -> cadence_vec=5.
- Saturation: 300-cycle spacing (16384/300=54) -> cadence_vec=31 at R+7; same 7-cycle latency.
- Stall: after cadence_vec=16, no rise for 4095 cycles -> cadence_vec=0, not_pedaling=1, no vec_valid. Next rise produces no update; the following rise 1024 later gives cadence_vec=16.
- Reset mid-division: assert rst_n at R+4 -> all outputs are at reset values immediately, and no vec_valid follows after release.
